booth_multiplier_param: RTL and testbench
=========================================

// Module: booth_multiplier_param
// PURPOSE
//  Parametrised sequential multiplier, successor to the fixed 64x64 shift-add unit.
//  Booth-recoded datapath, selectable signed/unsigned per operation, busy flag.
//  Same op_start/op_clear/op_done handshake. Feeds the ALU/MAC datapath.
// PARAMETERS
//  WIDTH  64  operand width in bits; even, >= 4; result is 2*WIDTH bits
// PORTS
//  clk           in   1          system clock, rising edge
//  reset_n       in   1          asynchronous active-low reset
//  multiplier    in   WIDTH      operand A, sampled on accepted op_start
//  multiplicand  in   WIDTH      operand B, sampled on accepted op_start
//  signed_mode   in   1          1 = two's-complement operands, 0 = unsigned; sampled with operands
//  op_start      in   1          start request, level-sensitive, honoured only in IDLE
//  op_clear      in   1          synchronous clear, highest priority after reset
//  op_busy       out  1          high while in EXEC
//  op_done       out  1          high while in DONE; result valid
//  result        out  2*WIDTH    product, held stable in DONE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, op_busy=0, op_done=0, result=0, counter=0.
//  FSM: IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: op_start=1 & op_clear=0 -> capture operands/mode, clear accumulator, load ITER, go EXEC.
//   EXEC: one Booth step per cycle, counter decrements; last step writes result, go DONE.
//   DONE: op_done=1, result held; op_start ignored (a held start never re-triggers);
//         op_clear=1 -> IDLE, op_done=0, result=0.
//  op_clear in any state: next edge -> IDLE, op_busy=0, op_done=0, result=0, op in flight discarded.
//  op_clear & op_start on the same edge: clear wins, no capture.
//  op_start while EXEC/DONE: ignored, operands not re-sampled.
//  Arithmetic: operands extended to N = WIDTH+2 bits (sign-extended if signed_mode=1,
//   zero-extended if 0); Booth recoding over N bits; result = low 2*WIDTH bits of N x N product
//   (exact for both modes). Partial-product adds in WIDTH+4 bit accumulator, arithmetic right shift.
//  Latency: capture edge = edge 0; op_busy=1 from edge 0 to edge ITER-1;
//   op_done and result valid after edge ITER.
//   ITER = WIDTH+2 (radix-2) or (WIDTH+2)/2 (radix-4). WIDTH=64: 66 / 33 cycles.
//  Async reset mid-EXEC: immediate return to reset state; no partial result visible.
//  result changes only on the DONE-entry edge and on clear/reset; stable otherwise.
// CONFIGURATION
//  BOOTH_RADIX4_EN defined: radix-4 Booth, 2 multiplier bits/cycle, digits {0,+-1,+-2}*B,
//   ITER=(WIDTH+2)/2.
//  BOOTH_RADIX4_EN undefined: radix-2 Booth, 1 bit/cycle, digits {0,+-1}*B, ITER=WIDTH+2.
//  Ports, handshake, results identical in both builds; only latency differs.
// TESTING (WIDTH=64; run every case in both builds)
//  1. unsigned 12 x 4, op_start held 10 cycles -> op_done after ITER edges, result=48; op_done holds, no restart; op_clear -> result=0.
//  2. signed -3 x 5 (signed_mode=1) -> result=128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1.
//  3. unsigned 64'hFFFF_FFFF_FFFF_FFFF squared -> result=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
//  4. signed 64'h8000_0000_0000_0000 squared -> result=128'h4000_0000_0000_0000_0000_0000_0000_0000;
//     same operands unsigned -> 128'h4000_0000_0000_0000_0000_0000_0000_0000 also (2^126).
//  5. op_clear at EXEC cycle 10 -> IDLE next edge, op_busy=0, op_done=0, result=0; new 7 x 6 -> 42.
//  6. reset_n low mid-EXEC (async, between edges) -> all outputs 0 immediately;
//     op_start+op_clear same edge in IDLE -> stays IDLE.

Source files
------------

// File: rtl/booth_multiplier_param.sv
// Sequential Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned per operation.
// Define BOOTH_RADIX4_EN for radix-4 recoding (half the latency); default build is radix-2.
module booth_multiplier_param #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 signed_mode,
  input  logic                 op_start,
  input  logic                 op_clear,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int N  = WIDTH + 2;
  localparam int AW = WIDTH + 4;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = (WIDTH + 2) / 2;
`else
  localparam int ITER = WIDTH + 2;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_LD = CW'(ITER);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r, next_state_s;
  logic                busy_nxt_s, done_nxt_s;
  logic                op_busy_r, op_done_r;
  logic [AW-1:0]       acc_r, acc_step_s, b_ext_s, pp_s, sum_s;
  logic [N-1:0]        q_r, q_step_s, mcand_r;
  logic                qm1_r, qm1_step_s;
  logic [CW-1:0]       cnt_r;
  logic [2*WIDTH-1:0]  result_r, result_nxt_s;

  // Both modes become exact signed N-bit operands: sign- or zero-extended by two bits.
  function automatic logic [N-1:0] extend_op(input logic [WIDTH-1:0] v, input logic sm);
    logic [N-1:0] r;
    if (sm) begin
      r = {{2{v[WIDTH-1]}}, v};
    end else begin
      r = {2'b00, v};
    end
    return r;
  endfunction

  assign b_ext_s = {{2{mcand_r[N-1]}}, mcand_r};

  // One Booth step: select partial product, add, arithmetic shift of {acc, q, q-1}.
  always_comb begin
    pp_s = {AW{1'b0}};
`ifdef BOOTH_RADIX4_EN
    case ({q_r[1:0], qm1_r})
      3'b001, 3'b010: pp_s = b_ext_s;
      3'b011:         pp_s = b_ext_s << 1;
      3'b100:         pp_s = -(b_ext_s << 1);
      3'b101, 3'b110: pp_s = -b_ext_s;
      default:        pp_s = {AW{1'b0}};
    endcase
    sum_s      = acc_r + pp_s;
    acc_step_s = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    q_step_s   = {sum_s[1:0], q_r[N-1:2]};
    qm1_step_s = q_r[1];
`else
    case ({q_r[0], qm1_r})
      2'b01:   pp_s = b_ext_s;
      2'b10:   pp_s = -b_ext_s;
      default: pp_s = {AW{1'b0}};
    endcase
    sum_s      = acc_r + pp_s;
    acc_step_s = {sum_s[AW-1], sum_s[AW-1:1]};
    q_step_s   = {sum_s[0], q_r[N-1:1]};
    qm1_step_s = q_r[0];
`endif
    result_nxt_s = {acc_step_s[2*WIDTH-N-1:0], q_step_s};
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      op_busy_r <= 1'b0;
      op_done_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      op_busy_r <= busy_nxt_s;
      op_done_r <= done_nxt_s;
    end
  end

  // Next-state logic; clear overrides everything, DONE leaves only on clear.
  always_comb begin
    next_state_s = state_r;
    if (op_clear) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_start) begin
            next_state_s = ST_EXEC;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_r == CNT_ONE) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_EXEC;
          end
        end
        ST_DONE: next_state_s = ST_DONE;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode of the upcoming state, registered alongside the state.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      ST_EXEC: busy_nxt_s = 1'b1;
      ST_DONE: done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration, result write on the final step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r    <= {AW{1'b0}};
      q_r      <= {N{1'b0}};
      qm1_r    <= 1'b0;
      mcand_r  <= {N{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {(2*WIDTH){1'b0}};
    end else if (op_clear) begin
      acc_r    <= {AW{1'b0}};
      q_r      <= {N{1'b0}};
      qm1_r    <= 1'b0;
      mcand_r  <= {N{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_start) begin
            acc_r   <= {AW{1'b0}};
            q_r     <= extend_op(multiplier, signed_mode);
            qm1_r   <= 1'b0;
            mcand_r <= extend_op(multiplicand, signed_mode);
            cnt_r   <= ITER_LD;
          end
        end
        ST_EXEC: begin
          acc_r <= acc_step_s;
          q_r   <= q_step_s;
          qm1_r <= qm1_step_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            result_r <= result_nxt_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign op_busy = op_busy_r;
  assign op_done = op_done_r;
  assign result  = result_r;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Scoreboard bench for booth_multiplier_param: directed corner cases plus random
// operations checked against plain-arithmetic products; honours BOOTH_RADIX4_EN.
module tb_booth_multiplier_param;

  localparam int W = 64;
`ifdef BOOTH_RADIX4_EN
  localparam int ITER = (W + 2) / 2;
`else
  localparam int ITER = W + 2;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [W-1:0]     multiplier, multiplicand;
  logic             signed_mode, op_start, op_clear;
  logic             op_busy, op_done;
  logic [2*W-1:0]   result;

  typedef struct {
    logic [2*W-1:0] exp;
    int             edge0;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  logic done_q = 1'b0;

  booth_multiplier_param #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .multiplier(multiplier), .multiplicand(multiplicand),
    .signed_mode(signed_mode), .op_start(op_start), .op_clear(op_clear),
    .op_busy(op_busy), .op_done(op_done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    logic signed [2*W-1:0] x, y;
    if (sm) begin
      x = {{W{a[W-1]}}, a};
      y = {{W{b[W-1]}}, b};
    end else begin
      x = {{W{1'b0}}, a};
      y = {{W{1'b0}}, b};
    end
    return x * y;
  endfunction

  // Monitor: pop the scoreboard on each op_done rise; result must read zero otherwise.
  always @(negedge clk) begin
    sb_t e;
    if (reset_n === 1'b1) begin
      if (op_done && !done_q) begin
        if (sb_q.size() == 0) begin
          chk1("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("result", result, e.exp);
          chk("latency", 128'(cyc - e.edge0), 128'(ITER));
        end
      end
      if (!op_done) chk("result_not_done", result, {(2*W){1'b0}});
      done_q = op_done;
    end else begin
      done_q = 1'b0;
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input bit push, input logic [2*W-1:0] exp_v, input bit keep);
    @(negedge clk);
    multiplier = a; multiplicand = b; signed_mode = sm; op_start = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb_q.push_back('{exp_v, cyc});
    chk1("busy_capture", op_busy, 1'b1);
    multiplier = {$urandom, $urandom};
    multiplicand = {$urandom, $urandom};
    signed_mode = ~sm;
    if (!keep) op_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!op_done && n < ITER + 4) begin
      @(negedge clk);
      n++;
    end
    chk1("done_timeout", op_done, 1'b1);
  endtask

  task automatic clear_check();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    chk1("clear_busy", op_busy, 1'b0);
    chk1("clear_done", op_done, 1'b0);
    chk("clear_result", result, {(2*W){1'b0}});
    op_clear = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input logic [2*W-1:0] exp_v);
    start_op(a, b, sm, 1'b1, exp_v, 1'b0);
    wait_done();
    clear_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic         sm;
    reset_n = 1'b0; multiplier = '0; multiplicand = '0;
    signed_mode = 1'b0; op_start = 1'b0; op_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_busy", op_busy, 1'b0);
    chk1("reset_done", op_done, 1'b0);
    chk("reset_result", result, {(2*W){1'b0}});
    @(negedge clk);
    reset_n = 1'b1;

    // held start: done persists, no restart
    start_op(64'd12, 64'd4, 1'b0, 1'b1, 128'd48, 1'b1);
    wait_done();
    repeat (10) @(negedge clk);
    chk1("done_hold", op_done, 1'b1);
    chk1("busy_in_done", op_busy, 1'b0);
    chk("result_hold", result, 128'd48);
    op_start = 1'b0;
    clear_check();

    run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
           128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
           128'h4000_0000_0000_0000_0000_0000_0000_0000);

    // clear in the middle of EXEC discards the operation
    start_op(64'd123456, 64'd789, 1'b0, 1'b0, 128'd0, 1'b0);
    repeat (9) @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    chk1("midclear_busy", op_busy, 1'b0);
    chk1("midclear_done", op_done, 1'b0);
    chk("midclear_result", result, {(2*W){1'b0}});
    op_clear = 1'b0;
    repeat (ITER + 4) @(negedge clk);
    run_op(64'd7, 64'd6, 1'b0, 128'd42);

    // async reset between edges during EXEC
    start_op(64'hDEAD_BEEF_0123_4567, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 128'd0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk1("async_busy", op_busy, 1'b0);
    chk1("async_done", op_done, 1'b0);
    chk("async_result", result, {(2*W){1'b0}});
    @(negedge clk);
    reset_n = 1'b1;

    // start and clear together: no capture
    @(negedge clk);
    op_start = 1'b1; op_clear = 1'b1;
    multiplier = 64'd3; multiplicand = 64'd3;
    @(posedge clk);
    #1;
    chk1("startclear_busy", op_busy, 1'b0);
    @(posedge clk);
    #1;
    chk1("startclear_busy2", op_busy, 1'b0);
    chk1("startclear_done", op_done, 1'b0);
    op_start = 1'b0; op_clear = 1'b0;

    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      sm = 1'($urandom_range(1, 0));
      case (i % 4)
        0: a = 64'h8000_0000_0000_0000;
        1: b = 64'hFFFF_FFFF_FFFF_FFFF;
        2: a = 64'h0000_0000_0000_0000;
        default: b = b;
      endcase
      run_op(a, b, sm, model(a, b, sm));
    end

    repeat (4) @(negedge clk);
    chk1("scoreboard_empty", sb_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
